target_responder: RTL and testbench
===================================

Name: target_responder

Overview:
- VGA pipeline stage that draws a horizontally moving target and detects hits from the projectile stage.
- Takes the bullet position from the shot stage and returns `hit_out`, which feeds the shot stage's `shoot_enable` so the bullet is removed on impact.
- Keeps a saturating hit score.
- Sits in the timing/rgb chain directly after the shot stage.

Parameters:
- TARGET_W, 32, target width in pixels
- TARGET_H, 16, target height in pixels
- TARGET_Y, 500, fixed top row of the target
- X_MIN, 0, leftmost target x
- X_MAX, 767, rightmost target x (800 - TARGET_W - 1)
- STEP, 2, pixels moved per frame
- FLASH_FRAMES, 30, frames the target flashes after a hit
- SCORE_W, 8, score counter width
- V_ACTIVE, 600, vcount value that defines the frame tick
- TARGET_COLOR, 12'h0_f_0, normal target colour
- FLASH_COLOR, 12'hf_f_f, colour while flashing

Ports:
- clk  in  1  posedge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- hcount_in  in  11  pixel column
- vcount_in  in  11  pixel row
- h_sync_in, v_sync_in, h_blank_in, v_blank_in  in  1 each  timing bus
- rgb_in  in  12  upstream pixel colour
- bullet_x  in  12  bullet top-left x
- bullet_y  in  12  bullet top-left y
- bullet_valid  in  1  bullet currently in flight
- hcount_out, vcount_out  out  11  timing bus, delayed
- h_sync_out, v_sync_out, h_blank_out, v_blank_out  out  1 each  timing bus, delayed
- rgb_out  out  12  composed pixel
- hit_out  out  1  one-cycle hit pulse
- score_out  out  SCORE_W  number of hits, saturating
- target_x_out  out  12  current target x

Behaviour:
- **Reset (rst=0, asynchronous):**
  - All outputs 0.
  - Internal state: target_x=X_MIN, dir=right, state=MOVE, flash counter 0, pipeline registers 0.
  - Reset asserted mid-operation aborts immediately; no hit pulse is emitted on release.
- **Timing bus latency:** exactly 2 cycles, input to output, for every timing and rgb signal.
- **Frame tick:** registered 1-cycle pulse, asserted the cycle after `vcount_in==V_ACTIVE && hcount_in==0`.
- **Hit condition:** evaluated every cycle on inputs, all compares in 13-bit unsigned. Overlap of the 4x4 bullet box and the target box requires all of:
  - bullet_valid=1
  - bullet_x <= target_x+TARGET_W-1
  - bullet_x+3 >= target_x
  - bullet_y <= TARGET_Y+TARGET_H-1
  - bullet_y+3 >= TARGET_Y
- **State MOVE:**
  - On hit condition:
    - next cycle hit_out=1 for exactly 1 cycle;
    - score +1, saturating at 2^SCORE_W-1;
    - go to FLASH with flash counter cleared;
    - target_x frozen.
  - Else on frame tick:
    - dir right: if target_x+STEP > X_MAX then target_x=X_MAX and dir=left, else target_x+=STEP.
    - dir left: if target_x < X_MIN+STEP then target_x=X_MIN and dir=right, else target_x-=STEP.
  - Hit and frame tick in the same cycle: hit wins, no move that frame.
- **State FLASH:**
  - Hits ignored; hit_out=0; target_x frozen.
  - Flash counter increments on each frame tick.
  - When the counter reaches FLASH_FRAMES-1 and a tick occurs, go to RESPAWN.
- **State RESPAWN:** lasts 1 cycle; sets target_x=X_MIN, dir=right, flash counter 0; then goes to MOVE.
- **Drawing (registered, aligned with the 2-cycle timing delay):**
  - Pixel is "in target" when all of: not h_blank, not v_blank, target_x <= hcount <= target_x+TARGET_W-1, and TARGET_Y <= vcount <= TARGET_Y+TARGET_H-1.
  - In target: rgb_out = TARGET_COLOR in MOVE/RESPAWN, FLASH_COLOR in FLASH.
  - Otherwise rgb_out = rgb_in, delayed by 2 cycles.
- **Mid-frame updates:** target_x changes only at the frame tick or in RESPAWN. A RESPAWN mid-frame may tear that one frame; this is accepted.
- **target_x_out:** registered copy of target_x, 1-cycle delay.

Test Plan:
- Reset release then 1 frame tick (vcount=600, hcount=0) -> target_x_out goes 0 -> 2; timing outputs equal inputs delayed 2 cycles.
- Bounce at the right edge -> target_x=766, dir right, tick -> 767 and dir left; next tick -> 765. Bounce at the left edge -> target_x=1, dir left, tick -> 0 and dir right.
- Hit at target_x=100 -> bullet (110,505) valid -> hit_out high exactly 1 cycle, score_out=1, in-rect pixels FFF; bullet (96,505) -> no hit; bullet (97,505) -> hit.
- After a hit, apply 30 frame ticks -> FLASH exits, RESPAWN, target_x_out=0, colour back to 0F0. A bullet overlapping during FLASH -> no hit_out, score unchanged.
- Score saturation -> force 255 hits (with flashes) -> score_out=255; a further hit still pulses hit_out and score stays 255.
- Hit and frame tick in the same cycle -> target_x unchanged, hit_out pulses. Assert rst=0 mid-FLASH -> all outputs 0 asynchronously, state MOVE after release.

Source files
------------

// File: rtl/target_responder_if.sv
// Pixel-stream and projectile bus for the target stage: timing/rgb in and out,
// bullet position in, hit/score/target position out, plus an FSM debug view.
interface target_responder_if #(
    parameter int SCORE_W = 8
);
    logic [10:0]        hcount_in;
    logic [10:0]        vcount_in;
    logic               h_sync_in;
    logic               v_sync_in;
    logic               h_blank_in;
    logic               v_blank_in;
    logic [11:0]        rgb_in;
    logic [11:0]        bullet_x;
    logic [11:0]        bullet_y;
    logic               bullet_valid;
    logic [10:0]        hcount_out;
    logic [10:0]        vcount_out;
    logic               h_sync_out;
    logic               v_sync_out;
    logic               h_blank_out;
    logic               v_blank_out;
    logic [11:0]        rgb_out;
    logic               hit_out;
    logic [SCORE_W-1:0] score_out;
    logic [11:0]        target_x_out;
    logic [1:0]         state_dbg;

    // Streaming bus: no valid/ready; every signal is sampled on every clock edge.
    modport slave (
        input  hcount_in, vcount_in, h_sync_in, v_sync_in, h_blank_in, v_blank_in,
               rgb_in, bullet_x, bullet_y, bullet_valid,
        output hcount_out, vcount_out, h_sync_out, v_sync_out, h_blank_out,
               v_blank_out, rgb_out, hit_out, score_out, target_x_out, state_dbg
    );

    modport master (
        output hcount_in, vcount_in, h_sync_in, v_sync_in, h_blank_in, v_blank_in,
               rgb_in, bullet_x, bullet_y, bullet_valid,
        input  hcount_out, vcount_out, h_sync_out, v_sync_out, h_blank_out,
               v_blank_out, rgb_out, hit_out, score_out, target_x_out, state_dbg
    );
endinterface

// File: rtl/target_responder.sv
// Moving target stage: bounces a box along a fixed row, detects bullet hits,
// flashes and respawns after a hit, and overlays the box on the pixel stream.
module target_responder #(
    parameter int          TARGET_W     = 32,
    parameter int          TARGET_H     = 16,
    parameter int          TARGET_Y     = 500,
    parameter int          X_MIN        = 0,
    parameter int          X_MAX        = 767,
    parameter int          STEP         = 2,
    parameter int          FLASH_FRAMES = 30,
    parameter int          SCORE_W      = 8,
    parameter int          V_ACTIVE     = 600,
    parameter logic [11:0] TARGET_COLOR = 12'h0f0,
    parameter logic [11:0] FLASH_COLOR  = 12'hfff
) (
    input  logic               clk,
    input  logic               rst,
    target_responder_if.slave  bus
);
    localparam int                CNT_W      = $clog2(FLASH_FRAMES + 1);
    localparam logic [12:0]       C_TW_M1    = 13'(TARGET_W - 1);
    localparam logic [12:0]       C_TY_TOP   = 13'(TARGET_Y);
    localparam logic [12:0]       C_TY_BOT   = 13'(TARGET_Y + TARGET_H - 1);
    localparam logic [12:0]       C_STEP     = 13'(STEP);
    localparam logic [12:0]       C_XMIN     = 13'(X_MIN);
    localparam logic [12:0]       C_XMAX     = 13'(X_MAX);
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

    typedef enum logic [1:0] {S_MOVE = 2'd0, S_FLASH = 2'd1, S_RESPAWN = 2'd2} state_t;

    state_t             r_state, w_state_nxt;
    logic [11:0]        r_target_x, w_tx_nxt;
    logic               r_dir_left, w_dir_nxt;
    logic [CNT_W-1:0]   r_flash_cnt, w_cnt_nxt;
    logic [SCORE_W-1:0] r_score, w_score_nxt;
    logic               r_hit, w_hit_nxt;
    logic               r_tick;
    logic [11:0]        r_tx_out;

    logic [10:0] r_hc1, r_vc1, r_hc2, r_vc2;
    logic        r_hs1, r_vs1, r_hb1, r_vb1, r_hs2, r_vs2, r_hb2, r_vb2;
    logic [11:0] r_rgb1, r_rgb2;

    logic [12:0] w_tx, w_bx, w_by, w_hc, w_vc;
    logic        w_hit_cond, w_in_tgt;

    assign w_tx = {1'b0, r_target_x};
    assign w_bx = {1'b0, bus.bullet_x};
    assign w_by = {1'b0, bus.bullet_y};
    assign w_hc = {2'b00, r_hc1};
    assign w_vc = {2'b00, r_vc1};

    // 4x4 bullet box against the target box, all in 13 bits so +3 cannot wrap.
    assign w_hit_cond = bus.bullet_valid
                     && (w_bx <= w_tx + C_TW_M1) && (w_bx + 13'd3 >= w_tx)
                     && (w_by <= C_TY_BOT)       && (w_by + 13'd3 >= C_TY_TOP);

    assign w_in_tgt = !r_hb1 && !r_vb1
                   && (w_hc >= w_tx) && (w_hc <= w_tx + C_TW_M1)
                   && (w_vc >= C_TY_TOP) && (w_vc <= C_TY_BOT);

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_target_x;
        w_dir_nxt   = r_dir_left;
        w_cnt_nxt   = r_flash_cnt;
        w_score_nxt = r_score;
        w_hit_nxt   = 1'b0;
        case (r_state)
            S_MOVE: begin
                // A hit in the same cycle as the frame tick suppresses that frame's move.
                if (w_hit_cond) begin
                    w_hit_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FLASH;
                    if (r_score != {SCORE_W{1'b1}})
                        w_score_nxt = r_score + 1'b1;
                end else if (r_tick) begin
                    if (!r_dir_left) begin
                        if (w_tx + C_STEP > C_XMAX) begin
                            w_tx_nxt  = C_XMAX[11:0];
                            w_dir_nxt = 1'b1;
                        end else begin
                            w_tx_nxt  = r_target_x + C_STEP[11:0];
                        end
                    end else begin
                        if (w_tx < C_XMIN + C_STEP) begin
                            w_tx_nxt  = C_XMIN[11:0];
                            w_dir_nxt = 1'b0;
                        end else begin
                            w_tx_nxt  = r_target_x - C_STEP[11:0];
                        end
                    end
                end
            end
            S_FLASH: begin
                if (r_tick) begin
                    if (r_flash_cnt == C_CNT_LAST)
                        w_state_nxt = S_RESPAWN;
                    else
                        w_cnt_nxt = r_flash_cnt + 1'b1;
                end
            end
            S_RESPAWN: begin
                w_tx_nxt    = C_XMIN[11:0];
                w_dir_nxt   = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_MOVE;
            end
            default: w_state_nxt = S_MOVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_MOVE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_target_x  <= 12'(X_MIN);
            r_dir_left  <= 1'b0;
            r_flash_cnt <= '0;
            r_score     <= '0;
            r_hit       <= 1'b0;
            r_tick      <= 1'b0;
            r_tx_out    <= '0;
        end else begin
            r_target_x  <= w_tx_nxt;
            r_dir_left  <= w_dir_nxt;
            r_flash_cnt <= w_cnt_nxt;
            r_score     <= w_score_nxt;
            r_hit       <= w_hit_nxt;
            r_tick      <= (bus.vcount_in == 11'(V_ACTIVE)) && (bus.hcount_in == 11'd0);
            r_tx_out    <= r_target_x;
        end
    end

    // Two-stage timing pipe; the overlay decision is made on stage 1 into stage 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hc1 <= '0; r_vc1 <= '0; r_hs1 <= 1'b0; r_vs1 <= 1'b0;
            r_hb1 <= 1'b0; r_vb1 <= 1'b0; r_rgb1 <= '0;
            r_hc2 <= '0; r_vc2 <= '0; r_hs2 <= 1'b0; r_vs2 <= 1'b0;
            r_hb2 <= 1'b0; r_vb2 <= 1'b0; r_rgb2 <= '0;
        end else begin
            r_hc1  <= bus.hcount_in;
            r_vc1  <= bus.vcount_in;
            r_hs1  <= bus.h_sync_in;
            r_vs1  <= bus.v_sync_in;
            r_hb1  <= bus.h_blank_in;
            r_vb1  <= bus.v_blank_in;
            r_rgb1 <= bus.rgb_in;
            r_hc2  <= r_hc1;
            r_vc2  <= r_vc1;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_hb2  <= r_hb1;
            r_vb2  <= r_vb1;
            r_rgb2 <= w_in_tgt ? ((r_state == S_FLASH) ? FLASH_COLOR : TARGET_COLOR) : r_rgb1;
        end
    end

    assign bus.hcount_out   = r_hc2;
    assign bus.vcount_out   = r_vc2;
    assign bus.h_sync_out   = r_hs2;
    assign bus.v_sync_out   = r_vs2;
    assign bus.h_blank_out  = r_hb2;
    assign bus.v_blank_out  = r_vb2;
    assign bus.rgb_out      = r_rgb2;
    assign bus.hit_out      = r_hit;
    assign bus.score_out    = r_score;
    assign bus.target_x_out = r_tx_out;
    assign bus.state_dbg    = r_state;
endmodule

// File: tb/tb_target_responder.sv
// Directed bench for target_responder: movement, bounce, hits, flash/respawn,
// score saturation and asynchronous reset, with hand-computed expectations.
module tb_target_responder;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    target_responder_if bus ();

    target_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.hcount_in    = '0;
        bus.vcount_in    = '0;
        bus.h_sync_in    = 1'b0;
        bus.v_sync_in    = 1'b0;
        bus.h_blank_in   = 1'b0;
        bus.v_blank_in   = 1'b0;
        bus.rgb_in       = '0;
        bus.bullet_x     = '0;
        bus.bullet_y     = '0;
        bus.bullet_valid = 1'b0;
    endtask

    // Frame-tick pixel for one cycle, then one more cycle for the FSM to act on it.
    task automatic tick_fast();
        bus.vcount_in = 11'd600;
        bus.hcount_in = 11'd0;
        step(1);
        bus.vcount_in = 11'd0;
        step(1);
    endtask

    // Tick plus the cycle needed for target_x_out to follow.
    task automatic tick();
        tick_fast();
        step(1);
    endtask

    task automatic pix(input string tag, input int h, input int v, input logic hb,
                       input logic [11:0] rgb, input logic [11:0] exp);
        bus.hcount_in  = 11'(h);
        bus.vcount_in  = 11'(v);
        bus.h_blank_in = hb;
        bus.rgb_in     = rgb;
        step(2);
        chk(tag, 16'(bus.rgb_out), 16'(exp));
        idle_inputs();
    endtask

    // Present a bullet for one cycle; returns with hit_out showing the registered result.
    task automatic shoot(input int x, input int y);
        bus.bullet_x     = 12'(x);
        bus.bullet_y     = 12'(y);
        bus.bullet_valid = 1'b1;
        step(1);
        bus.bullet_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_inputs();
        #3 rst = 1'b0;

        // Outputs must stay zero in reset even with live inputs.
        bus.hcount_in = 11'd77;  bus.vcount_in = 11'd88;  bus.h_sync_in = 1'b1;
        bus.rgb_in    = 12'habc; bus.v_blank_in = 1'b1;
        step(2);
        chk("rst_rgb",    16'(bus.rgb_out), 16'h0);
        chk("rst_hcount", 16'(bus.hcount_out), 16'h0);
        chk("rst_hsync",  16'(bus.h_sync_out), 16'h0);
        chk("rst_vblank", 16'(bus.v_blank_out), 16'h0);
        chk("rst_hit",    16'(bus.hit_out), 16'h0);
        chk("rst_score",  16'(bus.score_out), 16'h0);
        chk("rst_tx",     16'(bus.target_x_out), 16'h0);
        chk("rst_state",  16'(bus.state_dbg), 16'h0);

        idle_inputs();
        rst = 1'b1;
        step(3);
        chk("release_hit", 16'(bus.hit_out), 16'h0);

        // Two-cycle latency on the timing bus.
        bus.hcount_in = 11'd123; bus.vcount_in = 11'd45; bus.h_sync_in = 1'b1;
        bus.h_blank_in = 1'b1;   bus.rgb_in = 12'habc;
        step(1);
        bus.hcount_in = 11'd0;   bus.vcount_in = 11'd0;  bus.h_sync_in = 1'b0;
        bus.h_blank_in = 1'b0;   bus.rgb_in = 12'h000;
        chk("lat1_hcount", 16'(bus.hcount_out), 16'd0);
        step(1);
        chk("lat2_hcount", 16'(bus.hcount_out), 16'd123);
        chk("lat2_vcount", 16'(bus.vcount_out), 16'd45);
        chk("lat2_hsync",  16'(bus.h_sync_out), 16'd1);
        chk("lat2_hblank", 16'(bus.h_blank_out), 16'd1);
        chk("lat2_rgb",    16'(bus.rgb_out), 16'habc);
        step(1);
        chk("lat3_hcount", 16'(bus.hcount_out), 16'd0);

        tick();
        chk("first_tick_tx", 16'(bus.target_x_out), 16'd2);
        repeat (49) tick_fast();
        step(1);
        chk("tx_100", 16'(bus.target_x_out), 16'd100);

        // Overlay in MOVE at target_x=100: columns 100..131, rows 500..515.
        pix("draw_in_tl",   100, 500, 1'b0, 12'h123, 12'h0f0);
        pix("draw_left",     99, 500, 1'b0, 12'h123, 12'h123);
        pix("draw_in_br",   131, 515, 1'b0, 12'h123, 12'h0f0);
        pix("draw_right",   132, 500, 1'b0, 12'h123, 12'h123);
        pix("draw_below",   100, 516, 1'b0, 12'h456, 12'h456);
        pix("draw_above",   100, 499, 1'b0, 12'h456, 12'h456);
        pix("draw_hblank",  110, 505, 1'b1, 12'h789, 12'h789);

        shoot(96, 505);
        chk("miss96_hit",   16'(bus.hit_out), 16'd0);
        chk("miss96_score", 16'(bus.score_out), 16'd0);
        shoot(97, 505);
        chk("hit97_pulse",  16'(bus.hit_out), 16'd1);
        chk("hit97_score",  16'(bus.score_out), 16'd1);
        chk("hit97_state",  16'(bus.state_dbg), 16'd1);
        step(1);
        chk("hit97_one_cycle", 16'(bus.hit_out), 16'd0);
        pix("draw_flash", 110, 505, 1'b0, 12'h123, 12'hfff);

        shoot(110, 505);
        chk("flash_ignore_hit",   16'(bus.hit_out), 16'd0);
        step(1);
        chk("flash_ignore_score", 16'(bus.score_out), 16'd1);

        repeat (29) tick();
        chk("flash_29_state", 16'(bus.state_dbg), 16'd1);
        chk("flash_frozen_tx", 16'(bus.target_x_out), 16'd100);
        tick();
        step(1);
        chk("respawn_state", 16'(bus.state_dbg), 16'd0);
        chk("respawn_tx",    16'(bus.target_x_out), 16'd0);
        pix("draw_respawn", 0, 500, 1'b0, 12'h123, 12'h0f0);

        shoot(32, 505);
        chk("miss32_hit", 16'(bus.hit_out), 16'd0);

        // Tick registered this cycle, bullet overlapping in the same cycle.
        bus.vcount_in = 11'd600;
        bus.hcount_in = 11'd0;
        step(1);
        bus.vcount_in = 11'd0;
        shoot(31, 505);
        chk("tickhit_pulse", 16'(bus.hit_out), 16'd1);
        chk("tickhit_score", 16'(bus.score_out), 16'd2);
        step(2);
        chk("tickhit_no_move", 16'(bus.target_x_out), 16'd0);

        // Asynchronous reset in the middle of FLASH.
        bus.rgb_in = 12'hfff;
        step(2);
        chk("pre_rst_rgb", 16'(bus.rgb_out), 16'hfff);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_rgb",   16'(bus.rgb_out), 16'h0);
        chk("async_rst_score", 16'(bus.score_out), 16'h0);
        chk("async_rst_state", 16'(bus.state_dbg), 16'h0);
        step(1);
        idle_inputs();
        rst = 1'b1;
        step(1);
        chk("post_rst_state", 16'(bus.state_dbg), 16'd0);
        chk("post_rst_hit",   16'(bus.hit_out), 16'd0);

        // Right-edge bounce: 0 -> 766 in 383 ticks, then 767, then 765.
        repeat (383) tick_fast();
        step(1);
        chk("tx_766", 16'(bus.target_x_out), 16'd766);
        tick();
        chk("bounce_767", 16'(bus.target_x_out), 16'd767);
        tick();
        chk("bounce_765", 16'(bus.target_x_out), 16'd765);
        repeat (382) tick_fast();
        step(1);
        chk("tx_1", 16'(bus.target_x_out), 16'd1);
        tick();
        chk("bounce_0", 16'(bus.target_x_out), 16'd0);
        tick();
        chk("bounce_2", 16'(bus.target_x_out), 16'd2);

        // Drive the score to saturation: hit, full flash, respawn, repeat.
        for (int i = 0; i < 255; i++) begin
            shoot(5, 505);
            repeat (30) tick_fast();
            step(1);
        end
        chk("score_255", 16'(bus.score_out), 16'd255);
        shoot(5, 505);
        chk("sat_hit_pulse", 16'(bus.hit_out), 16'd1);
        chk("sat_score",     16'(bus.score_out), 16'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
